data_sram_resp: RTL and testbench



---
 rtl/data_sram_resp_pkg.sv | 22 ++
 rtl/sram_resp_queue.sv | 85 ++++++++
 rtl/data_sram_resp.sv | 86 ++++++++
 tb/tb_data_sram_resp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data-port SRAM responder: access sizes, byte strobes, LFSR seed.
package data_sram_resp_pkg;

   localparam logic [1:0]  SIZE_BYTE = 2'd0;
   localparam logic [1:0]  SIZE_HALF = 2'd1;
   localparam logic [1:0]  SIZE_WORD = 2'd2;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Misaligned halfword/word accesses drop the low address bits; size 3 writes nothing.
   function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] strb;
      case (size)
         SIZE_BYTE: strb = 4'b0001 << addr_lo;
         SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: strb = 4'b1111;
         default:   strb = 4'b0000;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/sram_resp_queue.sv
// In-order response FIFO: per-entry countdown timer, read-data capture one cycle after push,
// and a RAM-output bypass for heads that become due before their capture lands (LAT = 1).
module sram_resp_queue
   import data_sram_resp_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int LAT   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  logic        push_wr_i,
   input  logic        pop_i,
   input  logic [31:0] ram_rdata_i,
   output logic        full_o,
   output logic        head_ready_o,
   output logic [31:0] head_data_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = (LAT > 1) ? $clog2(LAT) : 1;

   logic [DEPTH-1:0] wr_q;
   logic [DEPTH-1:0] cap_q;
   logic [31:0]      data_q  [DEPTH];
   logic [TW-1:0]    timer_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    cap_idx_q;
   logic             cap_pend_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o       = (count_q == CW'(DEPTH));
   assign head_ready_o = (count_q != '0) && (timer_q[rd_ptr_q] == '0);
   assign count_d      = count_q + CW'(push_i) - CW'(pop_i);

   always_comb begin
      head_data_o = 32'h0;
      if (!wr_q[rd_ptr_q]) begin
         head_data_o = cap_q[rd_ptr_q] ? data_q[rd_ptr_q] : ram_rdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cap_idx_q  <= '0;
         cap_pend_q <= 1'b0;
         count_q    <= '0;
      end else begin
         cap_pend_q <= push_i;
         cap_idx_q  <= wr_ptr_q;
         for (int i = 0; i < DEPTH; i++) begin
            if (timer_q[i] != '0) begin
               timer_q[i] <= timer_q[i] - 1'b1;
            end
         end
         // The capture slot never equals the push slot: that would require a push while full.
         if (cap_pend_q) begin
            cap_q[cap_idx_q] <= 1'b1;
            if (!wr_q[cap_idx_q]) begin
               data_q[cap_idx_q] <= ram_rdata_i;
            end
         end
         if (push_i) begin
            wr_q[wr_ptr_q]    <= push_wr_i;
            cap_q[wr_ptr_q]   <= 1'b0;
            timer_q[wr_ptr_q] <= TW'(LAT - 1);
            wr_ptr_q          <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/data_sram_resp.sv
// Slave end of the data_req/data_addr_ok/data_data_ok handshake over a byte-enabled sync RAM.
// In-order responses LAT cycles after acceptance; DATA_SRAM_RESP_RANDOM_STALL_EN adds LFSR backpressure.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 2,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [31:0]       data_addr,
   input  logic [31:0]       data_wdata,
   output logic [31:0]       data_rdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   logic        q_full;
   logic        q_head_ready;
   logic [31:0] q_head_data;
   logic        accept;
   logic        pop;
   logic        acc_gate;
   logic        resp_gate;
   logic        unused_addr_hi;

`ifdef DATA_SRAM_RESP_RANDOM_STALL_EN
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign acc_gate  = (lfsr_q[1:0] != 2'b00);
   assign resp_gate = (lfsr_q[3:2] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign acc_gate  = 1'b1;
   assign resp_gate = 1'b1;
`endif

   // No full bypass: a pop in the same cycle does not open a slot for a new request.
   assign data_addr_ok = data_req && !q_full && acc_gate && !rst;
   assign accept       = data_addr_ok;
   assign pop          = q_head_ready && resp_gate && !rst;

   assign data_data_ok = pop;
   assign data_rdata   = pop ? q_head_data : 32'h0;

   assign ram_en    = accept;
   assign ram_we    = (accept && data_wr) ? byte_strobe(data_size, data_addr[1:0]) : 4'b0000;
   assign ram_addr  = accept ? data_addr[ADDR_W+1:2] : '0;
   assign ram_wdata = accept ? data_wdata : 32'h0;

   assign unused_addr_hi = ^data_addr[31:ADDR_W+2];

   sram_resp_queue #(
      .DEPTH (DEPTH),
      .LAT   (LAT)
   ) u_queue (
      .clk          (clk),
      .rst          (rst),
      .push_i       (accept),
      .push_wr_i    (data_wr),
      .pop_i        (pop),
      .ram_rdata_i  (ram_rdata),
      .full_o       (q_full),
      .head_ready_o (q_head_ready),
      .head_data_o  (q_head_data)
   );

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench: two responders (DEPTH=2/LAT=3 and DEPTH=1/LAT=1) over behavioural RAMs.
module tb_data_sram_resp;
   import data_sram_resp_pkg::*;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req   [2];
   logic        wr    [2];
   logic [1:0]  size  [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        aok   [2];
   logic        dok   [2];
   logic        ren   [2];
   logic [3:0]  rwe   [2];
   logic [7:0]  raddr [2];
   logic [31:0] rwdata[2];
   logic [31:0] rrdata[2];
   logic [31:0] mem   [2][256];

   exp_t q0[$];
   exp_t q1[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_sram_resp #(.ADDR_W(8), .DEPTH(2), .LAT(3)) u_dut0 (
      .clk(clk), .rst(rst), .data_req(req[0]), .data_wr(wr[0]), .data_size(size[0]),
      .data_addr(addr[0]), .data_wdata(wdata[0]), .data_rdata(rdata[0]),
      .data_addr_ok(aok[0]), .data_data_ok(dok[0]), .ram_en(ren[0]), .ram_we(rwe[0]),
      .ram_addr(raddr[0]), .ram_wdata(rwdata[0]), .ram_rdata(rrdata[0])
   );

   data_sram_resp #(.ADDR_W(8), .DEPTH(1), .LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .data_req(req[1]), .data_wr(wr[1]), .data_size(size[1]),
      .data_addr(addr[1]), .data_wdata(wdata[1]), .data_rdata(rdata[1]),
      .data_addr_ok(aok[1]), .data_data_ok(dok[1]), .ram_en(ren[1]), .ram_we(rwe[1]),
      .ram_addr(raddr[1]), .ram_wdata(rwdata[1]), .ram_rdata(rrdata[1])
   );

   // Synchronous single-port RAMs with byte write enables.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (ren[d]) begin
            for (int b = 0; b < 4; b++) begin
               if (rwe[d][b]) mem[d][raddr[d]][b*8 +: 8] <= rwdata[d][b*8 +: 8];
            end
            if (rwe[d] == 4'b0000) rrdata[d] <= mem[d][raddr[d]];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? 3 : 1;
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            if (dok[d]) begin
               if (qsize(d) == 0) begin
                  chk($sformatf("spurious_data_ok%0d", d), {31'h0, dok[d]}, 32'h0);
               end else begin
                  if (d == 0) mon_e = q0.pop_front();
                  else        mon_e = q1.pop_front();
                  chk($sformatf("resp_rdata%0d", d), rdata[d], mon_e.data);
                  chk($sformatf("resp_cycle%0d", d), cyc, mon_e.due);
               end
            end else begin
               chk($sformatf("idle_rdata%0d", d), rdata[d], 32'h0);
            end
         end
      end
   end

   task automatic issue(input int d, input bit w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] exp_we, input logic [31:0] exp_rd,
                        input int exp_stalls, input bit track);
      int   stalls = 0;
      exp_t e;
      req[d] = 1'b1; wr[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd;
      @(negedge clk);
      while (!aok[d] && stalls < 40) begin
         chk("stall_ram_en", {31'h0, ren[d]}, 32'h0);
         stalls++;
         @(negedge clk);
      end
      chk("addr_ok", {31'h0, aok[d]}, 32'h1);
      chk("stall_cycles", stalls, exp_stalls);
      chk("ram_en", {31'h0, ren[d]}, 32'h1);
      chk("ram_we", {28'h0, rwe[d]}, {28'h0, exp_we});
      chk("ram_addr", {24'h0, raddr[d]}, {24'h0, a[9:2]});
      chk("ram_wdata", rwdata[d], wd);
      if (track) begin
         e.data = w ? 32'h0 : exp_rd;
         e.due  = cyc + lat_of(d);
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      @(posedge clk);
      #1;
      req[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      int n = 0;
      while (qsize(d) != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("drain_pending", qsize(d), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input int d);
      chk("rst_addr_ok",  {31'h0, aok[d]}, 32'h0);
      chk("rst_data_ok",  {31'h0, dok[d]}, 32'h0);
      chk("rst_rdata",    rdata[d], 32'h0);
      chk("rst_ram_en",   {31'h0, ren[d]}, 32'h0);
      chk("rst_ram_we",   {28'h0, rwe[d]}, 32'h0);
      chk("rst_ram_addr", {24'h0, raddr[d]}, 32'h0);
      chk("rst_ram_wdata", rwdata[d], 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 256; i++) mem[d][i] = 32'h0;
         req[d] = 1'b1; wr[d] = 1'b1; size[d] = SIZE_WORD;
         addr[d] = 32'h100; wdata[d] = 32'h5555_5555;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs(0);
      chk_reset_outputs(1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req[0] = 1'b0; req[1] = 1'b0;
      mon_en = 1'b1;

      // Word write then immediate read of the same word.
      issue(0, 1, SIZE_WORD, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 1);
      issue(0, 0, SIZE_WORD, 32'h100, 32'h0, 4'b0000, 32'hDEADBEEF, 0, 1);
      drain(0);

      issue(0, 1, SIZE_WORD, 32'h100, 32'h0, 4'b1111, 32'h0, 0, 1);
      issue(0, 1, SIZE_BYTE, 32'h102, 32'h00AB0000, 4'b0100, 32'h0, 0, 1);
      drain(0);
      issue(0, 0, SIZE_WORD, 32'h100, 32'h0, 4'b0000, 32'h00AB0000, 0, 1);
      drain(0);

      // Halfwords, one of them misaligned.
      issue(0, 1, SIZE_HALF, 32'h206, 32'h12340000, 4'b1100, 32'h0, 0, 1);
      issue(0, 1, SIZE_HALF, 32'h205, 32'h00005678, 4'b0011, 32'h0, 0, 1);
      drain(0);
      issue(0, 0, SIZE_WORD, 32'h204, 32'h0, 4'b0000, 32'h12345678, 0, 1);
      drain(0);

      // Reserved size writes nothing; misaligned word; upper address bits ignored.
      issue(0, 1, 2'd3, 32'h204, 32'hFFFFFFFF, 4'b0000, 32'h0, 0, 1);
      issue(0, 1, SIZE_WORD, 32'h10B, 32'hCAFEF00D, 4'b1111, 32'h0, 0, 1);
      drain(0);
      issue(0, 1, SIZE_BYTE, 32'h103, 32'h77000000, 4'b1000, 32'h0, 0, 1);
      issue(0, 0, SIZE_WORD, 32'hFFFFF100, 32'h0, 4'b0000, 32'h77AB0000, 0, 1);
      drain(0);

      // Back-to-back reads: third request waits for the first response plus one cycle.
      issue(0, 0, SIZE_WORD, 32'h204, 32'h0, 4'b0000, 32'h12345678, 0, 1);
      issue(0, 0, SIZE_WORD, 32'h108, 32'h0, 4'b0000, 32'hCAFEF00D, 0, 1);
      issue(0, 0, SIZE_WORD, 32'h100, 32'h0, 4'b0000, 32'h77AB0000, 2, 1);
      issue(0, 0, SIZE_HALF, 32'h206, 32'h0, 4'b0000, 32'h12345678, 0, 1);
      drain(0);

      // Reset with two reads outstanding: their responses must never appear.
      issue(0, 0, SIZE_WORD, 32'h100, 32'h0, 4'b0000, 32'h0, 0, 0);
      issue(0, 0, SIZE_WORD, 32'h108, 32'h0, 4'b0000, 32'h0, 0, 0);
      rst = 1'b1;
      req[0] = 1'b1; wr[0] = 1'b1; size[0] = SIZE_WORD; addr[0] = 32'h100; wdata[0] = 32'hBAD0BAD0;
      @(negedge clk);
      chk_reset_outputs(0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req[0] = 1'b0;
      issue(0, 0, SIZE_WORD, 32'h108, 32'h0, 4'b0000, 32'hCAFEF00D, 0, 1);
      drain(0);
      issue(0, 0, SIZE_WORD, 32'h100, 32'h0, 4'b0000, 32'h77AB0000, 0, 1);
      drain(0);
      repeat (6) @(posedge clk);
      #1;

      // DEPTH=1, LAT=1: responses via the RAM bypass, one request every other cycle.
      issue(1, 1, SIZE_WORD, 32'h300, 32'h11223344, 4'b1111, 32'h0, 0, 1);
      issue(1, 0, SIZE_WORD, 32'h300, 32'h0, 4'b0000, 32'h11223344, 1, 1);
      issue(1, 0, SIZE_WORD, 32'h300, 32'h0, 4'b0000, 32'h11223344, 1, 1);
      issue(1, 1, SIZE_BYTE, 32'h301, 32'h0000AA00, 4'b0010, 32'h0, 1, 1);
      issue(1, 0, SIZE_WORD, 32'h300, 32'h0, 4'b0000, 32'h1122AA44, 1, 1);
      drain(1);
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
